issue_scoreboard: RTL and testbench

- Issue/hazard controller between decode and execute in the RV32I pipeline.
- Holds a per-register pending-write scoreboard for x1..x31.
- Stalls a decoded instruction while any source it reads, or a saturated destination, still has writes in flight.
- Retirement from writeback (or squash) releases entries. Also exports a busy mask, a stall-cycle counter and a protocol-error flag.

---
 rtl/issue_scoreboard_pkg.sv | 11 +
 rtl/issue_scoreboard_sb_counter.sv | 40 ++++
 rtl/issue_scoreboard.sv | 112 +++++++++++
 tb/tb_issue_scoreboard.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// rtl/issue_scoreboard_pkg.sv - shared types and constants for the issue scoreboard
package issue_scoreboard_pkg;

  localparam int NUM_REGS  = 32;
  localparam int IDX_W     = 5;
  localparam int CNT_W_DEF = 2;

  typedef logic [IDX_W-1:0]     reg_idx_t;
  typedef logic [CNT_W_DEF-1:0] pend_cnt_t;

endpackage

// File: rtl/issue_scoreboard_sb_counter.sv
// rtl/issue_scoreboard_sb_counter.sv - per-register pending-write up/down counter with underflow flag
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic [1:0]       i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_underflow
);

  localparam int SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [SW-1:0]    sum;
  logic [SW-1:0]    diff;
  logic [CNT_W-1:0] cnt_next;

  // Net change for this cycle; clamp at 0 (flagging underflow) and at MAX.
  always_comb begin
    sum         = SW'(o_cnt) + SW'(i_inc);
    diff        = sum - SW'(i_dec);
    o_underflow = 1'b0;
    cnt_next    = diff[CNT_W-1:0];
    if (sum < SW'(i_dec)) begin
      o_underflow = 1'b1;
      cnt_next    = '0;
    end else if (diff > SW'(MAX)) begin
      cnt_next    = MAX;
    end
  end

  // Counter state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) o_cnt <= '0;
    else        o_cnt <= cnt_next;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - RV32I decode/execute issue scoreboard; optional ISSUE_SCOREBOARD_BYPASS_EN
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_dec_valid,
  output logic                   o_dec_ready,
  input  logic [4:0]             i_rs1_raddr,
  input  logic [4:0]             i_rs2_raddr,
  input  logic                   i_uses_rs1,
  input  logic                   i_uses_rs2,
  input  logic [4:0]             i_rd,
  input  logic                   i_reg_write,
  input  logic                   i_ex_ready,
  input  logic                   i_flush,
  output logic                   o_issue,
  output logic                   o_stall,
  input  logic                   i_wb_valid,
  input  logic [4:0]             i_wb_rd,
  input  logic                   i_kill_valid,
  input  logic [4:0]             i_kill_rd,
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
  output logic                   o_fwd_rs1,
  output logic                   o_fwd_rs2,
`endif
  output logic [NUM_REGS-1:0]    o_busy_mask,
  output logic [STALL_CNT_W-1:0] o_stall_cnt,
  output logic                   o_err
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] underflow;
  logic                raw1, raw2, waw, hazard;
  logic                byp1, byp2;

  // x0 is never tracked.
  assign cnt[0]       = '0;
  assign underflow[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_cnt
      logic       inc;
      logic [1:0] dec;
      assign inc = o_issue & i_reg_write & (i_rd == reg_idx_t'(r));
      assign dec = {1'b0, i_wb_valid & (i_wb_rd == reg_idx_t'(r))}
                 + {1'b0, i_kill_valid & (i_kill_rd == reg_idx_t'(r))};
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_inc       (inc),
        .i_dec       (dec),
        .o_cnt       (cnt[r]),
        .o_underflow (underflow[r])
      );
    end
  endgenerate

  // Hazard detection and same-cycle issue handshake.
  always_comb begin
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
    byp1 = (cnt[i_rs1_raddr] == ONE) & i_wb_valid & (i_wb_rd == i_rs1_raddr);
    byp2 = (cnt[i_rs2_raddr] == ONE) & i_wb_valid & (i_wb_rd == i_rs2_raddr);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    raw1   = i_uses_rs1 & (i_rs1_raddr != '0) & (cnt[i_rs1_raddr] != '0) & ~byp1;
    raw2   = i_uses_rs2 & (i_rs2_raddr != '0) & (cnt[i_rs2_raddr] != '0) & ~byp2;
    waw    = i_reg_write & (i_rd != '0) & (cnt[i_rd] == MAX);
    hazard = raw1 | raw2 | waw;
    if (i_flush) begin
      o_issue     = 1'b0;
      o_stall     = 1'b0;
      o_dec_ready = i_dec_valid;
    end else begin
      o_issue     = i_dec_valid & ~hazard & i_ex_ready;
      o_stall     = i_dec_valid & hazard;
      o_dec_ready = o_issue;
    end
  end

`ifdef ISSUE_SCOREBOARD_BYPASS_EN
  assign o_fwd_rs1 = i_uses_rs1 & (i_rs1_raddr != '0) & byp1;
  assign o_fwd_rs2 = i_uses_rs2 & (i_rs2_raddr != '0) & byp2;
`endif

  // Busy view derived from the registered counters.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) o_busy_mask[i] = (cnt[i] != '0);
  end

  // Sticky error on any release against an empty counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)          o_err <= 1'b0;
    else if (|underflow) o_err <= 1'b1;
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                       o_stall_cnt <= '0;
    else if (o_stall && !(&o_stall_cnt)) o_stall_cnt <= o_stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed self-checking bench for issue_scoreboard
module tb_issue_scoreboard;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_dec_valid, i_uses_rs1, i_uses_rs2, i_reg_write, i_ex_ready, i_flush;
  logic [4:0]  i_rs1_raddr, i_rs2_raddr, i_rd, i_wb_rd, i_kill_rd;
  logic        i_wb_valid, i_kill_valid;
  logic        o_dec_ready, o_issue, o_stall, o_err;
  logic [31:0] o_busy_mask;
  logic [31:0] o_stall_cnt;
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
  logic        o_fwd_rs1, o_fwd_rs2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  issue_scoreboard dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_dec_valid  (i_dec_valid),
    .o_dec_ready  (o_dec_ready),
    .i_rs1_raddr  (i_rs1_raddr),
    .i_rs2_raddr  (i_rs2_raddr),
    .i_uses_rs1   (i_uses_rs1),
    .i_uses_rs2   (i_uses_rs2),
    .i_rd         (i_rd),
    .i_reg_write  (i_reg_write),
    .i_ex_ready   (i_ex_ready),
    .i_flush      (i_flush),
    .o_issue      (o_issue),
    .o_stall      (o_stall),
    .i_wb_valid   (i_wb_valid),
    .i_wb_rd      (i_wb_rd),
    .i_kill_valid (i_kill_valid),
    .i_kill_rd    (i_kill_rd),
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
    .o_fwd_rs1    (o_fwd_rs1),
    .o_fwd_rs2    (o_fwd_rs2),
`endif
    .o_busy_mask  (o_busy_mask),
    .o_stall_cnt  (o_stall_cnt),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then let combinational outputs settle.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_dec_valid = 0; i_uses_rs1 = 0; i_uses_rs2 = 0; i_reg_write = 0;
    i_rs1_raddr = 0; i_rs2_raddr = 0; i_rd = 0; i_flush = 0; i_ex_ready = 1;
    i_wb_valid = 0; i_wb_rd = 0; i_kill_valid = 0; i_kill_rd = 0;
  endtask

  task automatic dec_write(input logic [4:0] rd);
    idle(); i_dec_valid = 1; i_reg_write = 1; i_rd = rd;
  endtask

  initial begin
    idle();
    i_rst = 0;
    #12;
    chk("rst_busy", o_busy_mask, 32'h0);
    chk("rst_stall_cnt", o_stall_cnt, 32'd0);
    chk("rst_err", {31'b0, o_err}, 32'd0);
    #3 i_rst = 1;
    tick();

    // Clean source read issues immediately.
    i_dec_valid = 1; i_rs1_raddr = 5; i_uses_rs1 = 1; #1;
    chk("first_issue", {31'b0, o_issue}, 32'd1);
    chk("first_ready", {31'b0, o_dec_ready}, 32'd1);
    chk("first_busy", o_busy_mask, 32'h0);
    chk("first_stall_cnt", o_stall_cnt, 32'd0);

    // RAW on x5: three stall cycles, then retire cycle still stalls.
    dec_write(5); #1;
    chk("wr5_issue", {31'b0, o_issue}, 32'd1);
    tick();
    chk("busy5", o_busy_mask, 32'h0000_0020);
    idle(); i_dec_valid = 1; i_rs1_raddr = 5; i_uses_rs1 = 1; #1;
    chk("raw5_stall", {31'b0, o_stall}, 32'd1);
    chk("raw5_ready", {31'b0, o_dec_ready}, 32'd0);
    tick(); tick(); tick();
    i_wb_valid = 1; i_wb_rd = 5; #1;
    chk("raw5_wb_stall", {31'b0, o_stall}, 32'd1);
    tick();
    i_wb_valid = 0; #1;
    chk("raw5_after_issue", {31'b0, o_issue}, 32'd1);
    chk("raw5_stall_cnt", o_stall_cnt, 32'd4);
    chk("raw5_busy_clear", o_busy_mask, 32'h0);

    // x0 is never tracked.
    dec_write(0); tick();
    idle(); i_dec_valid = 1; i_uses_rs1 = 1; i_uses_rs2 = 1; #1;
    chk("x0_issue", {31'b0, o_issue}, 32'd1);
    chk("x0_stall", {31'b0, o_stall}, 32'd0);
    chk("x0_busy", o_busy_mask, 32'h0);

    // WAW saturation on x7.
    dec_write(7); tick(); tick(); tick();
    chk("busy7", o_busy_mask, 32'h0000_0080);
    #1;
    chk("waw7_stall", {31'b0, o_stall}, 32'd1);
    chk("waw7_issue", {31'b0, o_issue}, 32'd0);
    i_wb_valid = 1; i_wb_rd = 7; #1;
    chk("waw7_wb_stall", {31'b0, o_stall}, 32'd1);
    tick();
    i_wb_valid = 0; #1;
    chk("waw7_reissue", {31'b0, o_issue}, 32'd1);
    tick();
    chk("waw7_still_full", {31'b0, o_stall}, 32'd1);
    chk("waw7_stall_cnt", o_stall_cnt, 32'd5);

    // wb and kill together release two; then the last one.
    idle(); i_wb_valid = 1; i_wb_rd = 7; i_kill_valid = 1; i_kill_rd = 7;
    tick();
    chk("x7_after_dual", o_busy_mask, 32'h0000_0080);
    idle(); i_kill_valid = 1; i_kill_rd = 7;
    tick();
    chk("x7_drained", o_busy_mask, 32'h0);
    chk("x7_no_err", {31'b0, o_err}, 32'd0);

    // Back-pressure alone does not stall.
    idle(); i_dec_valid = 1; i_ex_ready = 0; #1;
    chk("bp_issue", {31'b0, o_issue}, 32'd0);
    chk("bp_stall", {31'b0, o_stall}, 32'd0);
    chk("bp_ready", {31'b0, o_dec_ready}, 32'd0);

    // Flush drops the instruction without reserving rd.
    dec_write(9); i_flush = 1; #1;
    chk("flush_ready", {31'b0, o_dec_ready}, 32'd1);
    chk("flush_issue", {31'b0, o_issue}, 32'd0);
    tick();
    chk("flush_busy", o_busy_mask, 32'h0);

    // Issue and retire on same register cancel out.
    dec_write(9); tick();
    dec_write(9); i_wb_valid = 1; i_wb_rd = 9; #1;
    chk("x9_issue_wb", {31'b0, o_issue}, 32'd1);
    tick();
    chk("x9_busy", o_busy_mask, 32'h0000_0200);

    // Release to x0 is ignored; release to empty x3 is a sticky error.
    idle(); i_wb_valid = 1; i_wb_rd = 0; tick();
    chk("wb_x0_no_err", {31'b0, o_err}, 32'd0);
    idle(); i_wb_valid = 1; i_wb_rd = 3; tick();
    chk("err_set", {31'b0, o_err}, 32'd1);
    idle(); tick();
    chk("err_sticky", {31'b0, o_err}, 32'd1);
    chk("x9_still_busy", o_busy_mask, 32'h0000_0200);

`ifdef ISSUE_SCOREBOARD_BYPASS_EN
    dec_write(4); tick();
    idle(); i_dec_valid = 1; i_uses_rs2 = 1; i_rs2_raddr = 4;
    i_wb_valid = 1; i_wb_rd = 4; #1;
    chk("byp_issue", {31'b0, o_issue}, 32'd1);
    chk("byp_fwd_rs2", {31'b0, o_fwd_rs2}, 32'd1);
    chk("byp_fwd_rs1", {31'b0, o_fwd_rs1}, 32'd0);
    tick();
`endif

    chk("final_stall_cnt", o_stall_cnt, 32'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
